// File: rtl/amo_multi_reservation_unit_pkg.sv
// Shared load-store types: AMO opcodes, reservation granule and agent index width.
package riscv_types;

  typedef enum logic [3:0] {
    AMO_SWAP,
    AMO_ADD,
    AMO_XOR,
    AMO_AND,
    AMO_OR,
    AMO_MIN,
    AMO_MAX,
    AMO_MINU,
    AMO_MAXU
  } amo_t;

  localparam int RES_WORDS = 4;
  localparam int RES_W     = 30 - $clog2(RES_WORDS);

  typedef logic [RES_W-1:0] res_granule_t;

  function automatic int agent_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/amo_multi_reservation_unit_alu.sv
// Combinational atomic ALU: a is the memory operand, b the register operand.
import riscv_types::*;

module amo_alu #(
  parameter int WIDTH = 32
) (
  input  amo_t             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  logic w_lt_s;
  logic w_lt_u;

  assign w_lt_s = $signed(i_a) < $signed(i_b);
  assign w_lt_u = i_a < i_b;

  always_comb begin
    o_y = i_b;
    unique case (i_op)
      AMO_SWAP: o_y = i_b;
      AMO_ADD:  o_y = i_a + i_b;
      AMO_XOR:  o_y = i_a ^ i_b;
      AMO_AND:  o_y = i_a & i_b;
      AMO_OR:   o_y = i_a | i_b;
      AMO_MIN:  o_y = w_lt_s ? i_a : i_b;
      AMO_MAX:  o_y = w_lt_s ? i_b : i_a;
      AMO_MINU: o_y = w_lt_u ? i_a : i_b;
      AMO_MAXU: o_y = w_lt_u ? i_b : i_a;
      default:  o_y = i_b;
    endcase
  end

endmodule

// File: rtl/amo_multi_reservation_unit.sv
// Per-agent LR/SC reservations with snoop invalidation and a round-robin AMO port.
// Optional reservation lifetime bound: define AMO_RESERVATION_TIMEOUT_EN.
import riscv_types::*;

module amo_multi_reservation_unit #(
  parameter int NUM_UNITS           = 3,
  parameter int RESERVATION_WORDS   = 4,
  parameter int RESERVATION_TIMEOUT = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_UNITS-1:0]                set_reservation,
  input  logic [NUM_UNITS-1:0]                clear_reservation,
  input  logic [NUM_UNITS-1:0][31:0]          reservation_addr,
  output logic [NUM_UNITS-1:0]                reservation_valid,
  input  logic [NUM_UNITS-1:0]                write_valid,
  input  logic [NUM_UNITS-1:0][31:0]          write_addr,
  input  logic [NUM_UNITS-1:0]                rmw_req,
  output logic [NUM_UNITS-1:0]                rmw_grant,
  input  amo_t [NUM_UNITS-1:0]                op,
  input  logic [NUM_UNITS-1:0][31:0]          rs1,
  input  logic [NUM_UNITS-1:0][31:0]          rs2,
  output logic                                rmw_done,
  output logic [agent_idx_w(NUM_UNITS)-1:0]   rmw_done_id,
  output logic [31:0]                         rd
);

  localparam int GW = 30 - $clog2(RESERVATION_WORDS);
  localparam int IW = agent_idx_w(NUM_UNITS);

  logic [NUM_UNITS-1:0]         r_valid;
  logic [NUM_UNITS-1:0][GW-1:0] r_addr;
  logic [NUM_UNITS-1:0]         w_snoop;
  logic [IW-1:0]                r_ptr;
  logic [IW-1:0]                w_gidx;
  logic                         w_any;
  logic [31:0]                  w_y;

  // Snoop: only another agent's write can kill a reservation.
  always_comb begin
    w_snoop = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      for (int j = 0; j < NUM_UNITS; j++) begin
        if (j != i && write_valid[j] &&
            write_addr[j][31 -: GW] == r_addr[i])
          w_snoop[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++)
      reservation_valid[i] = r_valid[i] &&
        (r_addr[i] == reservation_addr[i][31 -: GW]);
  end

`ifdef AMO_RESERVATION_TIMEOUT_EN
  localparam int CW = $clog2(RESERVATION_TIMEOUT + 1);

  logic [NUM_UNITS-1:0][CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (set_reservation[i])
          r_cnt[i] <= CW'(RESERVATION_TIMEOUT - 1);
        else if (r_valid[i] && r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_addr  <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (set_reservation[i]) begin
          r_valid[i] <= 1'b1;
          r_addr[i]  <= reservation_addr[i][31 -: GW];
        end else if (clear_reservation[i] || w_snoop[i]) begin
          r_valid[i] <= 1'b0;
`ifdef AMO_RESERVATION_TIMEOUT_EN
        end else if (r_valid[i] && r_cnt[i] == '0) begin
          r_valid[i] <= 1'b0;
`endif
        end
      end
    end
  end

  // First requester at or after the pointer, wrapping.
  always_comb begin
    rmw_grant = '0;
    w_gidx    = '0;
    w_any     = 1'b0;
    for (int off = 0; off < NUM_UNITS; off++) begin : g_scan
      int idx;
      idx = int'(r_ptr) + off;
      if (idx >= NUM_UNITS)
        idx = idx - NUM_UNITS;
      if (!w_any && rmw_req[idx]) begin
        w_any          = 1'b1;
        w_gidx         = IW'(idx);
        rmw_grant[idx] = 1'b1;
      end
    end
  end

  amo_alu #(
    .WIDTH (32)
  ) u_alu (
    .i_op (op[w_gidx]),
    .i_a  (rs1[w_gidx]),
    .i_b  (rs2[w_gidx]),
    .o_y  (w_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      rmw_done    <= 1'b0;
      rmw_done_id <= '0;
      rd          <= '0;
    end else begin
      rmw_done <= w_any;
      if (w_any) begin
        r_ptr       <= (w_gidx == IW'(NUM_UNITS - 1)) ? '0 : w_gidx + 1'b1;
        rmw_done_id <= w_gidx;
        rd          <= w_y;
      end
    end
  end

endmodule

// File: tb/tb_amo_multi_reservation_unit.sv
// Directed bench for amo_multi_reservation_unit with a result scoreboard.
import riscv_types::*;

module tb_amo_multi_reservation_unit;

  localparam int N = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       set_reservation;
  logic [N-1:0]       clear_reservation;
  logic [N-1:0][31:0] reservation_addr;
  logic [N-1:0]       reservation_valid;
  logic [N-1:0]       write_valid;
  logic [N-1:0][31:0] write_addr;
  logic [N-1:0]       rmw_req;
  logic [N-1:0]       rmw_grant;
  amo_t [N-1:0]       op;
  logic [N-1:0][31:0] rs1;
  logic [N-1:0][31:0] rs2;
  logic               rmw_done;
  logic [1:0]         rmw_done_id;
  logic [31:0]        rd;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  amo_multi_reservation_unit #(
    .NUM_UNITS           (N),
    .RESERVATION_WORDS   (4),
    .RESERVATION_TIMEOUT (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .set_reservation   (set_reservation),
    .clear_reservation (clear_reservation),
    .reservation_addr  (reservation_addr),
    .reservation_valid (reservation_valid),
    .write_valid       (write_valid),
    .write_addr        (write_addr),
    .rmw_req           (rmw_req),
    .rmw_grant         (rmw_grant),
    .op                (op),
    .rs1               (rs1),
    .rs2               (rs2),
    .rmw_done          (rmw_done),
    .rmw_done_id       (rmw_done_id),
    .rd                (rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    check({tag, "_done"}, 32'(rmw_done), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_id"}, 32'(rmw_done_id), 32'(e.id));
      check({tag, "_rd"}, rd, e.rd);
    end
  endtask

  initial begin
    int order[4];
    exp_t e;
    order = '{0, 1, 2, 0};

    rst               = 1'b1;
    set_reservation   = '0;
    clear_reservation = '0;
    reservation_addr  = '0;
    write_valid       = '0;
    write_addr        = '0;
    rmw_req           = '0;
    for (int i = 0; i < N; i++) begin
      op[i]  = AMO_ADD;
      rs1[i] = 32'd10;
      rs2[i] = 32'(i + 1);
    end
    tick();
    tick();
    check("rst_done", 32'(rmw_done), 32'd0);
    check("rst_id", 32'(rmw_done_id), 32'd0);
    check("rst_rd", rd, 32'd0);
    check("rst_rv", 32'(reservation_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Granule hit / miss for agent 0
    set_reservation[0]  = 1'b1;
    reservation_addr[0] = 32'h1000;
    tick();
    set_reservation     = '0;
    reservation_addr[0] = 32'h100C;
    #1 check("probe_100c", 32'(reservation_valid[0]), 32'd1);
    reservation_addr[0] = 32'h1010;
    #1 check("probe_1010", 32'(reservation_valid[0]), 32'd0);

    // Own write keeps, foreign write kills
    set_reservation[1]  = 1'b1;
    reservation_addr[1] = 32'h2000;
    tick();
    set_reservation     = '0;
    check("r1_set", 32'(reservation_valid[1]), 32'd1);
    write_valid[1] = 1'b1;
    write_addr[1]  = 32'h2004;
    tick();
    write_valid = '0;
    check("own_write", 32'(reservation_valid[1]), 32'd1);
    write_valid[2] = 1'b1;
    write_addr[2]  = 32'h2004;
    tick();
    write_valid = '0;
    check("snoop_kill", 32'(reservation_valid[1]), 32'd0);

    // Set wins over same-cycle foreign write
    set_reservation[0]  = 1'b1;
    reservation_addr[0] = 32'h3000;
    write_valid[1]      = 1'b1;
    write_addr[1]       = 32'h3000;
    tick();
    set_reservation = '0;
    write_valid     = '0;
    check("set_vs_write", 32'(reservation_valid[0]), 32'd1);

    // Round-robin AMOADD stream
    rmw_req = '1;
    for (int c = 0; c < 4; c++) begin
      #1 check($sformatf("grant%0d", c), 32'(rmw_grant),
               32'(1 << order[c]));
      e.id = 2'(order[c]);
      e.rd = 32'd10 + 32'(order[c] + 1);
      sb.push_back(e);
      tick();
      check_result($sformatf("res%0d", c));
    end
    rmw_req = '0;
    tick();
    check("done_drop", 32'(rmw_done), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Reservation lifetime
    clear_reservation = '1;
    tick();
    clear_reservation   = '0;
    set_reservation[2]  = 1'b1;
    reservation_addr[2] = 32'h4000;
    tick();
    set_reservation = '0;
`ifdef AMO_RESERVATION_TIMEOUT_EN
    for (int n = 1; n <= 4; n++) begin
      check($sformatf("tmo_live%0d", n), 32'(reservation_valid[2]), 32'd1);
      tick();
    end
    check("tmo_expired", 32'(reservation_valid[2]), 32'd0);
`else
    for (int n = 1; n < 100; n++)
      tick();
    check("no_tmo_k100", 32'(reservation_valid[2]), 32'd1);
`endif

    // Reset mid-operation
    set_reservation     = 2'b11;
    reservation_addr[0] = 32'h5000;
    reservation_addr[1] = 32'h6000;
    tick();
    set_reservation = '0;
    check("pre_rst_rv", 32'(reservation_valid[1:0]), 32'd3);
    rmw_req = '1;
    #1 check("pre_rst_grant", 32'(rmw_grant), 32'b010);
    tick();
    rmw_req = '0;
    check("pre_rst_done", 32'(rmw_done), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_done", 32'(rmw_done), 32'd0);
    check("arst_id", 32'(rmw_done_id), 32'd0);
    check("arst_rd", rd, 32'd0);
    check("arst_rv", 32'(reservation_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", 32'(rmw_done), 32'd0);
    rmw_req = '1;
    #1 check("post_rst_grant", 32'(rmw_grant), 32'b001);
    e.id = 2'd0;
    e.rd = 32'd11;
    sb.push_back(e);
    tick();
    rmw_req = '0;
    check_result("post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
